// File: rtl/timer_core_param.sv
// timer_core_param: BCD stopwatch / countdown timer driving active-low 7-segment digits.
// Defining TIMER_LAP_EN adds a lap-hold display register; without it the Lap input is ignored.
module timer_core_param #(
   parameter int                  DIGITS   = 4,
   parameter int                  TICK_DIV = 500000,
   parameter logic [4*DIGITS-1:0] PRESET   = (4*DIGITS)'(16'h3000)
) (
   input  logic                  CLK_50MHz,
   input  logic                  rst,
   input  logic                  StartStop,
   input  logic                  ModeSel,
   input  logic                  Lap,
   output logic [7*DIGITS-1:0]   HexOut,
   output logic                  DOT,
   output logic                  Done,
   output logic                  Running
);
   localparam int CW = 4*DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} stateT;

   function automatic logic [CW-1:0] bcdInc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcdDec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] segEncode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Input bit order: [0] StartStop, [1] ModeSel, [2] Lap (lap build only)
`ifdef TIMER_LAP_EN
   localparam int NIN = 3;
   logic [NIN-1:0] asyncIn;
   assign asyncIn = {Lap, ModeSel, StartStop};
`else
   localparam int NIN = 2;
   logic [NIN-1:0] asyncIn;
   logic           unusedLap;
   assign asyncIn   = {ModeSel, StartStop};
   assign unusedLap = Lap;
`endif

   logic [NIN-1:0] syncA, syncB, syncPrev;
   logic           startEdge, modeChange, mode, tick, doneEvent;
   stateT          state, nextState;
   logic [CW-1:0]  count, nextCount, incVal, decVal, dispVal;
   logic [PW-1:0]  pre, nextPre;
   logic [7*DIGITS-1:0] nextHex;

   assign startEdge  = syncB[0] & ~syncPrev[0];
   assign modeChange = syncB[1] ^ syncPrev[1];
   assign mode       = syncB[1];
   assign incVal     = bcdInc(count);
   assign decVal     = bcdDec(count);

   // Two-flop synchronizers plus previous-value flops for edge detection
   always_ff @(posedge CLK_50MHz or posedge rst) begin
      if (rst) begin
         syncA    <= {NIN{1'b0}};
         syncB    <= {NIN{1'b0}};
         syncPrev <= {NIN{1'b0}};
      end else begin
         syncA    <= asyncIn;
         syncB    <= syncA;
         syncPrev <= syncB;
      end
   end

   // Next-state, count, prescaler and done-event logic; a mode change overrides everything
   always_comb begin
      nextState = state;
      nextCount = count;
      nextPre   = pre;
      doneEvent = 1'b0;
      tick      = (state == RUN) && (pre == PRE_LAST);
      if (modeChange) begin
         nextState = IDLE;
         nextPre   = {PW{1'b0}};
         nextCount = mode ? PRESET : {CW{1'b0}};
      end else begin
         if (state == RUN) begin
            nextPre = tick ? {PW{1'b0}} : pre + PW'(1);
         end else begin
            nextPre = pre;
         end
         case (state)
            IDLE: begin
               if (startEdge && !(mode && (count == {CW{1'b0}}))) begin
                  nextState = RUN;
               end else begin
                  nextState = IDLE;
               end
            end
            RUN: begin
               if (startEdge) begin
                  nextState = IDLE;
               end else if (tick && mode) begin
                  nextCount = decVal;
                  if (decVal == {CW{1'b0}}) begin
                     nextState = DONE;
                     doneEvent = 1'b1;
                  end else begin
                     nextState = RUN;
                  end
               end else if (tick) begin
                  nextCount = incVal;
                  doneEvent = (count == ALL_NINES);
               end else begin
                  nextState = RUN;
               end
            end
            DONE: begin
               if (startEdge) begin
                  nextCount = PRESET;
                  nextState = IDLE;
               end else begin
                  nextState = DONE;
               end
            end
            default: nextState = IDLE;
         endcase
      end
   end

   // State, count and prescaler registers
   always_ff @(posedge CLK_50MHz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= {CW{1'b0}};
         pre   <= {PW{1'b0}};
      end else begin
         state <= nextState;
         count <= nextCount;
         pre   <= nextPre;
      end
   end

`ifdef TIMER_LAP_EN
   logic          lapEdge, holdActive, nextHoldActive;
   logic [CW-1:0] holdVal, nextHoldVal;
   assign lapEdge = syncB[2] & ~syncPrev[2];

   // Lap hold: first stopwatch-RUN edge latches, any later stopwatch edge releases
   always_comb begin
      nextHoldActive = holdActive;
      nextHoldVal    = holdVal;
      if (modeChange) begin
         nextHoldActive = 1'b0;
      end else if (lapEdge && !mode) begin
         if (holdActive) begin
            nextHoldActive = 1'b0;
         end else if (state == RUN) begin
            nextHoldActive = 1'b1;
            nextHoldVal    = count;
         end else begin
            nextHoldActive = holdActive;
         end
      end else begin
         nextHoldActive = holdActive;
      end
   end

   // Lap hold registers
   always_ff @(posedge CLK_50MHz or posedge rst) begin
      if (rst) begin
         holdActive <= 1'b0;
         holdVal    <= {CW{1'b0}};
      end else begin
         holdActive <= nextHoldActive;
         holdVal    <= nextHoldVal;
      end
   end

   assign dispVal = holdActive ? holdVal : count;
`else
   assign dispVal = count;
`endif

   // Segment encoding of the displayed value
   always_comb begin
      nextHex = {7*DIGITS{1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         nextHex[7*i +: 7] = segEncode(dispVal[4*i +: 4]);
      end
   end

   // Registered outputs; Running tracks the state register exactly
   always_ff @(posedge CLK_50MHz or posedge rst) begin
      if (rst) begin
         HexOut  <= {DIGITS{7'b1000000}};
         DOT     <= 1'b1;
         Done    <= 1'b0;
         Running <= 1'b0;
      end else begin
         HexOut  <= nextHex;
         DOT     <= (state != RUN);
         Done    <= doneEvent;
         Running <= (nextState == RUN);
      end
   end
endmodule
